uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among NUM_REQ byte producers. Candidate producers: loopback echo, status reporter, command responder.
- Arbitrates round-robin and latches the winner's byte.
- Drives the transmitter's ld_tx_data/tx_data load handshake and waits for tx_empty before the next grant.
- Sits between the producers and the uart instance; replaces ad-hoc per-design load FSMs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_IDX_W, 2, width of the grant index; must equal ceil(log2(NUM_REQ)).
- LOAD_TIMEOUT, 16, cycles to wait in LOAD for tx_empty to fall before aborting.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i high: requester i holds a byte to send.
- req_data  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot, combinational; the byte transfers when req_valid[i] and req_ready[i] are both high at a clock edge.
- ld_tx_data  output  1  load strobe to the UART transmitter.
- tx_data  output  8  registered byte presented to the UART.
- tx_empty  input  1  UART transmitter idle/ready.
- grant_idx  output  REQ_IDX_W  index of the last accepted requester.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  sticky; set on LOAD timeout, cleared only by reset.

Behaviour:
- Reset values: ld_tx_data=0, tx_data=0, grant_idx=NUM_REQ-1 (so requester 0 has first priority), busy=0, timeout_err=0, state=IDLE, timeout counter=0.
- States:
  - IDLE: ready to accept a new byte.
  - LOAD: ld_tx_data held high, waiting for the UART to take the byte.
  - DRAIN: UART transmitting, waiting for tx_empty to return high.
- IDLE:
  - If tx_empty=1 and req_valid!=0, req_ready is one-hot at the first valid index searched from grant_idx+1 upward, wrapping modulo NUM_REQ.
  - Otherwise req_ready=0.
  - On the accepting edge: tx_data<=selected byte, grant_idx<=index, ld_tx_data<=1, counter<=0, state<=LOAD.
- LOAD:
  - req_ready=0; counter increments each cycle.
  - If tx_empty=0: ld_tx_data<=0, state<=DRAIN.
  - Else if counter==LOAD_TIMEOUT-1: ld_tx_data<=0, timeout_err<=1, state<=IDLE. The byte is dropped and not retried.
- DRAIN:
  - req_ready=0.
  - When tx_empty=1, state<=IDLE.
  - The next grant can occur one cycle later, at the earliest.
- Latency: the accepting edge is at the earliest the edge where req_valid rises, provided tx_empty=1 and the FSM is in IDLE. ld_tx_data is high on the following cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- No requester is granted twice while another valid requester is waiting.
- A requester dropping req_valid before being granted is legal: no transfer occurs and nothing is recorded.
- req_data is sampled only on the accepting edge; later changes do not affect tx_data.
- tx_empty=0 while in IDLE (external traffic or a UART still busy after reset): no grant until tx_empty=1.
- Reset asserted in any state forces reset values on the next edge and abandons any in-flight load. The UART's own reset governs the serial line.
- NUM_REQ=1 degenerates to a pass-through load sequencer with grant_idx constant 0.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants: ST_IDLE=2'd0, ST_LOAD=2'd1, ST_DRAIN=2'd2.
  - default LOAD_TIMEOUT.
  - byte width constant 8.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, last index.
  - Outputs: one-hot grant, index, any.
  - Reusable for a future rx-side dispatcher.

Test Plan:
- Single request: reset, tx_empty=1, req_valid=4'b0100, byte 8'hA5 -> req_ready=4'b0100 for one cycle, then tx_data=A5, ld_tx_data=1, grant_idx=2. The UART model drops tx_empty -> ld_tx_data=0, busy stays 1 until tx_empty=1.
- Round-robin: all four requesters valid continuously with bytes 10,11,12,13 and a UART model taking 20 cycles per byte -> UART receives 10,11,12,13,10 in that order.
- Back-pressure: tx_empty held 0 while req_valid=4'b0001 -> req_ready stays 0 and ld_tx_data stays 0. On tx_empty=1 -> grant within 1 cycle.
- Timeout: the UART model never drops tx_empty after the load -> after 16 cycles ld_tx_data=0, timeout_err=1, FSM back in IDLE. The next request is still served; timeout_err remains 1.
- Reset mid-operation: assert reset during DRAIN with req_valid=4'b1111 -> next cycle all outputs hold reset values. First grant after reset goes to requester 0.
- Withdrawn request: req_valid[1] pulses for one cycle while tx_empty=0 -> no transfer, grant_idx unchanged, and the UART sees no load.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the UART transmit arbiter
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_LOAD_TIMEOUT = 16;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker searching upward from the slot after i_last
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  // walk offsets from farthest to nearest so the nearest valid slot wins
  always_comb begin
    o_gnt = '0;
    o_idx = i_last;
    o_any = |i_req;
    for (int k = N; k >= 1; k--) begin
      if (i_req[(int'(i_last) + k) % N]) begin
        o_gnt = '0;
        o_gnt[(int'(i_last) + k) % N] = 1'b1;
        o_idx = IW'((int'(i_last) + k) % N);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among byte producers
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int REQ_IDX_W    = 2,
  parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ld_tx_data,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_empty,
  output logic [REQ_IDX_W-1:0]      grant_idx,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int CW = $clog2(LOAD_TIMEOUT) + 1;
  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_ld, r_to;
  logic [BYTE_W-1:0]     r_data;
  logic [REQ_IDX_W-1:0]  r_grant;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [REQ_IDX_W-1:0]  w_idx;
  logic                  w_any, w_accept, w_expire;

  rr_pick #(.N(NUM_REQ), .IW(REQ_IDX_W)) u_pick (
    .i_req  (req_valid),
    .i_last (r_grant),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_accept    = r_state == ST_IDLE && tx_empty && w_any;
  assign w_expire    = r_state == ST_LOAD && tx_empty && r_cnt == CW'(LOAD_TIMEOUT - 1);
  assign req_ready   = w_accept ? w_gnt : '0;
  assign ld_tx_data  = r_ld;
  assign tx_data     = r_data;
  assign grant_idx   = r_grant;
  assign busy        = r_state != ST_IDLE;
  assign timeout_err = r_to;

  // next state: accept in IDLE, leave LOAD when the UART takes the byte or the wait expires
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = w_accept ? ST_LOAD : ST_IDLE;
      ST_LOAD:  w_next = !tx_empty ? ST_DRAIN : (w_expire ? ST_IDLE : ST_LOAD);
      ST_DRAIN: w_next = tx_empty ? ST_IDLE : ST_DRAIN;
      default:  w_next = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // latch the winner's byte, drive the load strobe and time out a stuck load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_grant <= REQ_IDX_W'(NUM_REQ - 1);
      r_ld    <= 1'b0;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= req_data[int'(w_idx)*BYTE_W +: BYTE_W];
        r_grant <= w_idx;
        r_ld    <= 1'b1;
        r_cnt   <= '0;
      end else if (r_state == ST_LOAD) begin
        r_cnt <= r_cnt + 1'b1;
        if (!tx_empty || w_expire) r_ld <= 1'b0;
      end
      if (w_expire) r_to <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks against a transaction-level model
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TO = 16;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic        ld_tx_data, tx_empty, busy, timeout_err;
  logic [7:0]  tx_data;
  logic [1:0]  grant_idx;
  int          n_tests = 0;
  int          n_fail = 0;
  int          m_phase, m_age, m_last;
  logic [7:0]  m_byte;
  bit          m_ld, m_to;
  logic [3:0]  m_xfer;
  int          u_low, u_len;
  bit          u_auto, u_ignore, rand_mode;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_rr[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .ld_tx_data  (ld_tx_data),
    .tx_data     (tx_data),
    .tx_empty    (tx_empty),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_last  = NR - 1;
    m_byte  = 8'h00;
    m_ld    = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_step();
    int p;
    m_xfer = '0;
    if (reset) model_reset();
    else if (m_phase == 0) begin
      p = tx_empty ? pick(req_valid, m_last) : -1;
      if (p >= 0) begin
        m_byte    = req_data[p*8 +: 8];
        m_last    = p;
        m_ld      = 1'b1;
        m_age     = 0;
        m_phase   = 1;
        m_xfer[p] = 1'b1;
      end
    end else if (m_phase == 1) begin
      if (!tx_empty) begin
        m_ld    = 1'b0;
        m_phase = 2;
      end else if (m_age == TO - 1) begin
        m_ld    = 1'b0;
        m_to    = 1'b1;
        m_phase = 0;
      end
      m_age++;
    end else if (tx_empty) m_phase = 0;
  endtask

  task automatic uart_step();
    if (u_low > 0) begin
      tx_empty = 1'b0;
      u_low--;
    end else if (ld_tx_data && !u_ignore) begin
      tx_empty = 1'b0;
      rx_q.push_back(tx_data);
      u_low = u_len - 1;
      if (rand_mode) u_len = $urandom_range(1, 6);
    end else begin
      tx_empty = rand_mode ? ($urandom_range(0, 15) != 0) : 1'b1;
      if (rand_mode && !ld_tx_data) u_ignore = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic tick();
    int p;
    logic [3:0] er;
    if (u_auto) uart_step();
    #1;
    p  = pick(req_valid, m_last);
    er = (m_phase == 0 && tx_empty && p >= 0) ? 4'(1 << p) : 4'b0000;
    if (!reset) chk("req_ready", 32'(req_ready), 32'(er));
    chk("ld_tx_data", 32'(ld_tx_data), 32'(m_ld));
    chk("tx_data", 32'(tx_data), 32'(m_byte));
    chk("grant_idx", 32'(grant_idx), 32'(m_last));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
    model_step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; tx_empty = 1'b1;
    u_auto = 0; rand_mode = 0; u_ignore = 0; u_low = 0; u_len = 4; m_xfer = '0;
    repeat (2) @(negedge clk);
    model_reset();
    tick();
    chk("rst_grant", 32'(grant_idx), 32'd3);
    chk("rst_ld", 32'(ld_tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    // single request
    req_valid = 4'b0100; req_data = 32'h00A50000;
    #1 chk("t1_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("t1_ld", 32'(ld_tx_data), 32'd1);
    chk("t1_data", 32'(tx_data), 32'hA5);
    chk("t1_grant", 32'(grant_idx), 32'd2);
    req_valid = '0; tx_empty = 1'b0;
    tick();
    chk("t1_ld_drop", 32'(ld_tx_data), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_drain", 32'(busy), 32'd1);
    tx_empty = 1'b1;
    tick();
    chk("t1_idle", 32'(busy), 32'd0);
    // round-robin with a 20-cycle UART
    reset = 1'b1; tick(); reset = 1'b0;
    req_valid = 4'hF; req_data = 32'h13121110; u_auto = 1; u_len = 20; rx_q.delete();
    for (int c = 0; c < 400 && rx_q.size() < 5; c++) tick();
    chk("rr_count", 32'(rx_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) if (k < rx_q.size()) chk("rr_byte", 32'(rx_q[k]), 32'(exp_rr[k]));
    u_auto = 0; u_low = 0; req_valid = '0;
    // back-pressure
    reset = 1'b1; tick(); reset = 1'b0;
    tx_empty = 1'b0; req_valid = 4'b0001; req_data = 32'h0000005A;
    repeat (5) begin
      #1 chk("bp_ready", 32'(req_ready), 32'd0);
      tick();
      chk("bp_ld", 32'(ld_tx_data), 32'd0);
    end
    tx_empty = 1'b1;
    #1 chk("bp_release", 32'(req_ready), 32'b0001);
    tick();
    chk("bp_ld_on", 32'(ld_tx_data), 32'd1);
    chk("bp_data", 32'(tx_data), 32'h5A);
    req_valid = '0; tx_empty = 1'b0; tick(); tx_empty = 1'b1; tick();
    // timeout
    req_valid = 4'b0010; req_data = 32'h0000C300;
    tick();
    chk("to_grant", 32'(grant_idx), 32'd1);
    req_valid = '0;
    repeat (15) begin
      tick();
      chk("to_ld_hold", 32'(ld_tx_data), 32'd1);
    end
    tick();
    chk("to_ld_off", 32'(ld_tx_data), 32'd0);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    req_valid = 4'b1000; req_data = 32'h77000000;
    #1 chk("to_next_ready", 32'(req_ready), 32'b1000);
    tick();
    chk("to_next_data", 32'(tx_data), 32'h77);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    req_valid = '0; tx_empty = 1'b0; tick();
    // reset during DRAIN
    req_valid = 4'hF; req_data = 32'h44332211;
    tick();
    reset = 1'b1; tick();
    chk("mr_grant", 32'(grant_idx), 32'd3);
    chk("mr_err", 32'(timeout_err), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    reset = 1'b0; tx_empty = 1'b1;
    #1 chk("mr_first", 32'(req_ready), 32'b0001);
    tick();
    chk("mr_data", 32'(tx_data), 32'h11);
    req_valid = '0; tx_empty = 1'b0; tick(); tx_empty = 1'b1; tick();
    // withdrawn request while the UART is busy
    tx_empty = 1'b0; req_valid = 4'b0010; tick();
    req_valid = '0; tick();
    tx_empty = 1'b1;
    repeat (3) begin
      tick();
      chk("wd_ld", 32'(ld_tx_data), 32'd0);
      chk("wd_grant", 32'(grant_idx), 32'd0);
    end
    // randomized traffic
    rand_mode = 1; u_auto = 1; u_len = 3; u_low = 0;
    repeat (3000) begin
      tick();
      reset = ($urandom_range(0, 255) == 0);
      for (int i = 0; i < NR; i++) begin
        if (m_xfer[i]) begin
          req_data[i*8 +: 8] = 8'($urandom);
          req_valid[i] = 1'($urandom_range(0, 1));
        end else if (!req_valid[i]) begin
          req_data[i*8 +: 8] = 8'($urandom);
          req_valid[i] = ($urandom_range(0, 3) == 0);
        end else if ($urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
        if ($urandom_range(0, 7) == 0) req_data[i*8 +: 8] = 8'($urandom);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
